tsc_frame_rx: RTL and testbench

- Downstream consumer of the TSC hub serial link.
- On TSC trigger-detect (TRD) it pulses SBF to request the buffer, then deserialises the SD/CD stream.
- Stream order: 32-bit trigger timestamp, then N_SAMPLES bytes.
- Stores the frame in a local sample RAM and exposes it via a registered read port plus frame_valid/timeout status.

---
 rtl/tsc_pkg.sv | 25 ++
 rtl/tsc_sample_ram.sv | 38 +++
 rtl/tsc_frame_rx.sv | 191 +++++++++++++++++++
 tb/tb_tsc_frame_rx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared TSC link definitions: FSM state encoding seen on state watchers,
// and default frame geometry used by TSC-side and receiver-side blocks.
package tsc_pkg;

    localparam int unsigned N_SAMPLES_DEF = 32;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned TS_W_DEF      = 32;
    localparam int unsigned STATE_W       = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_REQ     = 3'd2,
        ST_RX_TS   = 3'd3,
        ST_RX_DATA = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } rx_state_e;

    // States in which a frame transfer is in flight and cannot be interrupted.
    function automatic logic is_busy(input rx_state_e s);
        return (s inside {ST_REQ, ST_RX_TS, ST_RX_DATA});
    endfunction

endpackage

// File: rtl/tsc_sample_ram.sv
// Sample store for one received frame.
// Ports: clk, rst_n (async, active-low, clears only the read register),
//        we/waddr/wdata write port, raddr/rdata registered read port.
// A read of the address being written in the same cycle returns the new data.
module tsc_sample_ram #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array, no reset: contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with write-first bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tsc_frame_rx.sv
// Receiver for the TSC hub serial link.
// On a trd rise (when armed) it waits SBF_DELAY cycles, pulses sbf, then
// shifts in a TS_W-bit timestamp and N_SAMPLES DATA_W-bit samples on cd rises
// (MSB first). Samples land in a local RAM read through rd_addr/rd_data.
// Ports: clk, reset (async active-low), arm, trd, sd, cd, sbf, rd_addr,
//        rd_data, trigtm, frame_valid, timeout_err, busy, state_out.
module tsc_frame_rx
    import tsc_pkg::*;
#(
    parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned TS_W      = TS_W_DEF,
    parameter int unsigned SBF_DELAY = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         trd,
    input  logic                         sd,
    input  logic                         cd,
    output logic                         sbf,
    input  logic [$clog2(N_SAMPLES)-1:0] rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic [TS_W-1:0]              trigtm,
    output logic                         frame_valid,
    output logic                         timeout_err,
    output logic                         busy,
    output logic [STATE_W-1:0]           state_out
);

    localparam int unsigned ADDR_W = $clog2(N_SAMPLES);
    localparam int unsigned BIT_W  = $clog2(TS_W) + 1;
    localparam int unsigned BYTE_W = ADDR_W + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT) + 1;
    localparam int unsigned WAIT_W = $clog2(SBF_DELAY) + 1;

    rx_state_e           state, state_d;
    logic                trd_q, cd_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    // Shift registers hold all but the final bit; the final bit comes straight from sd.
    logic [TS_W-2:0]     ts_sr;
    logic [DATA_W-2:0]   byte_sr;

    logic                trd_rise_c, cd_rise_c;
    logic                wait_last_c, ts_last_c, byte_last_c, frame_last_c, tmo_hit_c;
    logic                sbf_d, frame_valid_d, timeout_err_d, busy_d;
    logic                ram_we_c;
    logic [DATA_W-1:0]   ram_wdata_c;

    assign trd_rise_c   = trd & ~trd_q;
    assign cd_rise_c    = cd & ~cd_q;
    assign wait_last_c  = (wait_cnt == WAIT_W'(SBF_DELAY - 1));
    assign ts_last_c    = cd_rise_c && (bit_cnt == BIT_W'(TS_W - 1));
    assign byte_last_c  = cd_rise_c && (bit_cnt == BIT_W'(DATA_W - 1));
    assign frame_last_c = byte_last_c && (byte_cnt == BYTE_W'(N_SAMPLES - 1));
    // Next idle cycle would make TIMEOUT consecutive cycles without a cd rise.
    assign tmo_hit_c    = !cd_rise_c && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign ram_wdata_c  = {byte_sr, sd};
    assign state_out    = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    if (arm) state_d = ST_ARMED;
            ST_ARMED:   if (trd_rise_c) state_d = ST_REQ;
            ST_REQ:     if (wait_last_c) state_d = ST_RX_TS;
            ST_RX_TS: begin
                if (ts_last_c)      state_d = ST_RX_DATA;
                else if (tmo_hit_c) state_d = ST_ERR;
            end
            ST_RX_DATA: begin
                if (frame_last_c)   state_d = ST_DONE;
                else if (tmo_hit_c) state_d = ST_ERR;
            end
            ST_DONE:    if (arm) state_d = ST_ARMED;
            ST_ERR:     if (arm) state_d = ST_ARMED;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode; status flags track the state being entered.
    always_comb begin
        sbf_d         = 1'b0;
        frame_valid_d = 1'b0;
        timeout_err_d = 1'b0;
        busy_d        = 1'b0;
        ram_we_c      = 1'b0;
        sbf_d         = (state == ST_REQ) && wait_last_c;
        frame_valid_d = (state_d == ST_DONE);
        timeout_err_d = (state_d == ST_ERR);
        busy_d        = is_busy(state_d);
        ram_we_c      = (state == ST_RX_DATA) && byte_last_c;
    end

    // Edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trd_q       <= 1'b0;
            cd_q        <= 1'b0;
            sbf         <= 1'b0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            trd_q       <= trd;
            cd_q        <= cd;
            sbf         <= sbf_d;
            frame_valid <= frame_valid_d;
            timeout_err <= timeout_err_d;
            busy        <= busy_d;
        end
    end

    // Counters and deserialiser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            ts_sr    <= '0;
            byte_sr  <= '0;
            trigtm   <= '0;
        end else begin
            wait_cnt <= (state == ST_REQ) ? wait_cnt + WAIT_W'(1) : '0;

            if ((state == ST_RX_TS) || (state == ST_RX_DATA)) begin
                tmo_cnt <= cd_rise_c ? '0 : tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                ST_RX_TS: begin
                    if (cd_rise_c) begin
                        ts_sr <= {ts_sr[TS_W-3:0], sd};
                        if (ts_last_c) begin
                            bit_cnt <= '0;
                            trigtm  <= {ts_sr, sd};
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (cd_rise_c) begin
                        byte_sr <= {byte_sr[DATA_W-3:0], sd};
                        if (byte_last_c) begin
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt + BYTE_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
            endcase
        end
    end

    tsc_sample_ram #(
        .DEPTH  (N_SAMPLES),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (ram_we_c),
        .waddr (byte_cnt[ADDR_W-1:0]),
        .wdata (ram_wdata_c),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_tsc_frame_rx.sv
// Bench for tsc_frame_rx: randomized TSC-side stimulus checked against a
// frame-level model (expected RAM image, timestamp and event timing).
module tb_tsc_frame_rx;

    localparam int N         = 32;
    localparam int DW        = 8;
    localparam int TW        = 32;
    localparam int SBF_DELAY = 4;
    localparam int TIMEOUT   = 1024;

    localparam int S_IDLE = 0, S_ARMED = 1, S_RX_DATA = 4, S_DONE = 5, S_ERR = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0, trd = 1'b0, sd = 1'b0, cd = 1'b0;
    logic [4:0]    rd_addr = '0;
    logic          sbf, frame_valid, timeout_err, busy;
    logic [DW-1:0] rd_data;
    logic [TW-1:0] trigtm;
    logic [2:0]    state_out;

    tsc_frame_rx #(
        .N_SAMPLES (N), .DATA_W (DW), .TS_W (TW),
        .SBF_DELAY (SBF_DELAY), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .reset (reset), .arm (arm), .trd (trd), .sd (sd), .cd (cd),
        .sbf (sbf), .rd_addr (rd_addr), .rd_data (rd_data), .trigtm (trigtm),
        .frame_valid (frame_valid), .timeout_err (timeout_err), .busy (busy),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    int sbf_pulses = 0, sbf_hi = 0, last_sbf_cyc = -1, last_cd_cyc = 0;
    logic sbf_prev = 1'b0;

    logic [7:0]  ram_m [N];
    logic [31:0] trigtm_m;
    logic [7:0]  fb [N];
    bit          bitq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (sbf === 1'b1) begin
            sbf_hi++;
            if (!sbf_prev) begin
                sbf_pulses++;
                last_sbf_cyc = cyc;
            end
        end
        sbf_prev = (sbf === 1'b1);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic build(input logic [31:0] ts, input int nbytes, input int extra_bits);
        bitq.delete();
        for (int i = 31; i >= 0; i--) bitq.push_back(ts[i]);
        for (int b = 0; b < nbytes; b++)
            for (int i = 7; i >= 0; i--) bitq.push_back(fb[b][i]);
        for (int e = 0; e < extra_bits; e++) bitq.push_back(fb[nbytes][7-e]);
    endtask

    // Raise trd and expect sbf exactly SBF_DELAY+1 cycles after the pin rise.
    task automatic start_frame();
        int t0, p0;
        trd = 1'b0;
        tick();
        tick();
        trd = 1'b1;
        t0 = cyc;
        p0 = sbf_pulses;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sbf_pulses != p0) break;
        end
        chk("sbf_delay", (sbf_pulses != p0) ? last_sbf_cyc - t0 : -1, SBF_DELAY + 1);
    endtask

    // Serialise bitq on cd/sd; optionally re-toggle trd mid-stream.
    task automatic drive_bits(input int lo_min, input int lo_max, input int glitch_at);
        for (int i = 0; i < bitq.size(); i++) begin
            if (i == glitch_at) trd = 1'b0;
            if (i == glitch_at + 8) trd = 1'b1;
            cd = 1'b1;
            sd = bitq[i];
            last_cd_cyc = cyc;
            repeat ($urandom_range(lo_max, lo_min)) tick();
            cd = 1'b0;
            repeat ($urandom_range(lo_max, lo_min)) tick();
        end
    endtask

    task automatic wait_fv();
        for (int i = 0; i < 16 && frame_valid !== 1'b1; i++) tick();
        chk("frame_valid_set", frame_valid, 1);
    endtask

    task automatic check_ram(input string tag);
        for (int k = 0; k < N; k++) begin
            rd_addr = 5'(k);
            tick();
            chk($sformatf("%s[%0d]", tag, k), rd_data, ram_m[k]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sbf"}, sbf, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_trigtm"}, trigtm, 0);
        chk({tag, "_fv"}, frame_valid, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, state_out, S_IDLE);
    endtask

    task automatic finish_frame(input logic [31:0] ts, input string tag);
        wait_fv();
        for (int k = 0; k < N; k++) ram_m[k] = fb[k];
        trigtm_m = ts;
        chk({tag, "_trigtm"}, trigtm, trigtm_m);
        chk({tag, "_state"}, state_out, S_DONE);
        chk({tag, "_busy"}, busy, 0);
        check_ram(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] ts;
        int tcyc;

        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b1;
        tick();

        // Spurious cd/trd activity while idle (never armed).
        for (int i = 0; i < 6; i++) begin
            cd = 1'b1; tick(); cd = 1'b0; tick();
            trd = 1'b1; tick(); trd = 1'b0; tick();
        end
        chk("idle_state", state_out, S_IDLE);
        chk("idle_sbf_pulses", sbf_pulses, 0);
        chk("idle_busy", busy, 0);

        // Frame 1: TS 0xDEADBEEF, samples 0x00..0x1F, cd period 4, extra trd rise in data.
        arm_pulse();
        chk("armed_state", state_out, S_ARMED);
        for (int k = 0; k < N; k++) fb[k] = 8'(k);
        ts = 32'hDEADBEEF;
        build(ts, N, 0);
        start_frame();
        chk("busy_rx", busy, 1);
        drive_bits(2, 2, 32 + 40);
        finish_frame(ts, "f1");
        chk("f1_sbf_pulses", sbf_pulses, 1);

        // trd rise while DONE is ignored.
        trd = 1'b0; tick();
        trd = 1'b1; repeat (3) tick();
        chk("done_trd_state", state_out, S_DONE);
        chk("done_trd_sbf", sbf_pulses, 1);

        // Frame 2 overwrites: samples 0xA0..0xBF, TS 1.
        chk("fv_before_rearm", frame_valid, 1);
        arm_pulse();
        chk("fv_fall", frame_valid, 0);
        chk("rearm_state", state_out, S_ARMED);
        for (int k = 0; k < N; k++) fb[k] = 8'(8'hA0 + k);
        ts = 32'h0000_0001;
        build(ts, N, 0);
        start_frame();
        drive_bits(2, 2, -100);
        finish_frame(ts, "f2");

        // Timeout: TS plus 3 samples, then cd stops.
        arm_pulse();
        ts = $urandom;
        for (int k = 0; k < N; k++) fb[k] = 8'($urandom);
        build(ts, 3, 0);
        start_frame();
        drive_bits(1, 3, -100);
        for (int k = 0; k < 3; k++) ram_m[k] = fb[k];
        trigtm_m = ts;
        tcyc = -1;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            if (timeout_err === 1'b1) begin
                tcyc = cyc;
                break;
            end
            tick();
        end
        // The last cd rise is seen by the design at the edge after it was driven.
        chk("tmo_cycles", (tcyc >= 0) ? tcyc - (last_cd_cyc + 1) : -1, TIMEOUT);
        chk("tmo_fv", frame_valid, 0);
        chk("tmo_state", state_out, S_ERR);
        chk("tmo_busy", busy, 0);
        chk("tmo_trigtm", trigtm, trigtm_m);
        check_ram("tmo");
        arm_pulse();
        chk("tmo_clear", timeout_err, 0);
        chk("tmo_rearm_state", state_out, S_ARMED);

        // Randomized frames with irregular cd timing.
        for (int r = 0; r < 2; r++) begin
            if (r > 0) arm_pulse();
            ts = $urandom;
            for (int k = 0; k < N; k++) fb[k] = 8'($urandom);
            build(ts, N, 0);
            start_frame();
            drive_bits(1, 3, (r == 0) ? 40 : -100);
            finish_frame(ts, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset during sample 10.
        arm_pulse();
        rd_addr = 5'd5;
        ts = $urandom | 32'h1;
        for (int k = 0; k < N; k++) fb[k] = 8'($urandom) | 8'h01;
        build(ts, 10, 3);
        start_frame();
        drive_bits(1, 2, -100);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_state", state_out, S_RX_DATA);
        #2 reset = 1'b0;
        #1 check_reset_vals("async_rst");
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_state", state_out, S_IDLE);
        chk("post_rst_fv", frame_valid, 0);
        chk("post_rst_busy", busy, 0);

        chk("sbf_width", sbf_hi, sbf_pulses);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
